// File: rtl/bk_sector_engine_if.sv
// Save-RAM transfer bus: SD sector-buffer side plus the cart_top cram bk_* side.
// master = bk_sector_engine, slave = SD/image host and cart_top environment.
interface bk_sector_engine_if #(
    parameter int LBA_W = 32
);
    logic             bk_ena;
    logic             img_mounted;
    logic             img_readonly;
    logic [63:0]      img_size;
    logic [7:0]       ram_mask_file;
    logic             bk_load;
    logic             bk_save;
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [7:0]       sd_buff_addr;
    logic [15:0]      sd_buff_dout;
    logic             sd_buff_wr;
    logic [15:0]      sd_buff_din;
    logic [16:0]      bk_addr;
    logic [15:0]      bk_data;
    logic             bk_wr;
    logic             bk_rtc_wr;
    logic [15:0]      bk_q;
    logic             bk_busy;
    logic             bk_done;

    modport master (
        input  bk_ena, img_mounted, img_readonly, img_size, ram_mask_file,
               bk_load, bk_save, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, bk_q,
        output sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_data, bk_wr, bk_rtc_wr,
               bk_busy, bk_done
    );

    modport slave (
        output bk_ena, img_mounted, img_readonly, img_size, ram_mask_file,
               bk_load, bk_save, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, bk_q,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, bk_addr, bk_data, bk_wr, bk_rtc_wr,
               bk_busy, bk_done
    );
endinterface

// File: rtl/bk_sector_engine.sv
// Sector sequencer moving cart save RAM between the SD image and cart_top's cram bk_* port.
// Optional SAVE_RTC_EN: appends one RTC sector after the RAM area when the image is large enough.
module bk_sector_engine #(
    parameter int LBA_W    = 32,
    parameter int MAX_SECT = 256
) (
    input  logic              clk_sys,
    input  logic              reset,
    bk_sector_engine_if.master bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_ACK  = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [7:0] SECT_CAP = 8'(MAX_SECT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] lba_q, lba_d;
    logic [7:0] last_q, last_d;
    logic       rtc_q, rtc_d;
    logic       dir_load_q, dir_load_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       sd_rd_q, sd_rd_d;
    logic       sd_wr_q, sd_wr_d;
    logic       pend_q, pend_d;
    logic       load_prev_q, save_prev_q;

    logic       load_edge_s, save_edge_s, can_xfer_s, rtc_avail_s, in_rtc_s, xfer_wr_s;
    logic [7:0] img_last_s, nsect_raw_s, nsect_s, last_s;
    logic       unused_s;

    assign load_edge_s = (bus.bk_load & ~load_prev_q) | bus.img_mounted;
    assign save_edge_s = bus.bk_save & ~save_prev_q;
    assign can_xfer_s  = bus.bk_ena & (|bus.img_size[63:9]);

    // Images beyond 128KB saturate so the sector count cannot wrap.
    assign img_last_s  = (|bus.img_size[63:17]) ? 8'hFF : (bus.img_size[16:9] - 8'd1);
    assign nsect_raw_s = (bus.ram_mask_file < img_last_s) ? bus.ram_mask_file : img_last_s;
    assign nsect_s     = (nsect_raw_s > SECT_CAP) ? SECT_CAP : nsect_raw_s;

`ifdef SAVE_RTC_EN
    logic [63:0] rtc_need_s;
    assign rtc_need_s  = ({56'd0, nsect_s} + 64'd2) << 4'd9;
    // The RTC sector needs a free lba slot, so a full-size RAM area leaves no room for it.
    assign rtc_avail_s = (nsect_s < SECT_CAP) && (bus.img_size >= rtc_need_s);
    assign bus.bk_rtc_wr = xfer_wr_s & in_rtc_s;
`else
    assign rtc_avail_s   = 1'b0;
    assign bus.bk_rtc_wr = 1'b0;
`endif

    assign last_s    = nsect_s + {7'd0, rtc_avail_s};
    assign unused_s  = ^bus.img_size[8:0];
    assign in_rtc_s  = rtc_q & (lba_q == last_q);
    assign xfer_wr_s = busy_q & dir_load_q & bus.sd_ack & bus.sd_buff_wr;

    assign bus.bk_wr       = xfer_wr_s & ~in_rtc_s;
    assign bus.bk_addr     = in_rtc_s ? {1'b1, 8'h00, bus.sd_buff_addr} : {1'b0, lba_q, bus.sd_buff_addr};
    assign bus.bk_data     = bus.sd_buff_dout;
    assign bus.sd_buff_din = bus.bk_q;
    assign bus.sd_lba      = {{(LBA_W-8){1'b0}}, lba_q};
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign bus.bk_busy     = busy_q;
    assign bus.bk_done     = done_q;

    // Transfer sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        last_d     = last_q;
        rtc_d      = rtc_q;
        dir_load_d = dir_load_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sd_rd_d    = sd_rd_q;
        sd_wr_d    = sd_wr_q;
        pend_d     = pend_q | save_edge_s;
        case (state_q)
            ST_IDLE: begin
                if (load_edge_s && can_xfer_s) begin
                    state_d    = ST_REQ;
                    lba_d      = 8'd0;
                    last_d     = last_s;
                    rtc_d      = rtc_avail_s;
                    dir_load_d = 1'b1;
                    busy_d     = 1'b1;
                    sd_rd_d    = 1'b1;
                end else if ((save_edge_s || pend_q) && can_xfer_s && !bus.img_readonly) begin
                    state_d    = ST_REQ;
                    lba_d      = 8'd0;
                    last_d     = last_s;
                    rtc_d      = rtc_avail_s;
                    dir_load_d = 1'b0;
                    busy_d     = 1'b1;
                    sd_wr_d    = 1'b1;
                    pend_d     = 1'b0;
                end else begin
                    pend_d     = 1'b0;
                end
            end
            ST_REQ: begin
                if (bus.sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACK: begin
                if (!bus.sd_ack) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_NEXT: begin
                if (lba_q == last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    lba_d   = lba_q + 8'd1;
                    sd_rd_d = dir_load_q;
                    sd_wr_d = ~dir_load_q;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sd_rd_d = 1'b0;
                sd_wr_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, request edge detectors and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lba_q       <= 8'd0;
            last_q      <= 8'd0;
            rtc_q       <= 1'b0;
            dir_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            pend_q      <= 1'b0;
            load_prev_q <= 1'b0;
            save_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lba_q       <= lba_d;
            last_q      <= last_d;
            rtc_q       <= rtc_d;
            dir_load_q  <= dir_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            pend_q      <= pend_d;
            load_prev_q <= bus.bk_load;
            save_prev_q <= bus.bk_save;
        end
    end
endmodule
